cdb_arbiter: RTL and testbench

Parametrised common-data-bus arbiter for the out-of-order core. It collects result broadcasts from N_UNITS functional units (ALU, MFU, MMU, and future FPU and branch units). It grants up to N_LANES of them per cycle, either round-robin or fixed-priority. The granted payloads are registered onto N_LANES CDB lanes, which feed the reservation stations, register-file bypass and reorder buffer. It replaces the single-lane, combinational, fixed-priority CDB mux in the core top and adds multi-lane issue, fairness, a registered output and flush.

---
 rtl/cdb_arbiter.sv | 86 ++++++++
 tb/tb_cdb_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Multi-lane CDB arbiter: grants up to N_LANES valid units per cycle (round-robin or fixed priority)
// and registers their payloads onto the lanes. Latency 1 cycle; no backpressure, lanes are one-shot broadcasts.
module cdb_arbiter #(
  parameter int N_UNITS  = 3,
  parameter int N_LANES  = 1,
  parameter int RSV_ID_W = 8,
  parameter int DATA_W   = 32,
  parameter int CDB_W    = RSV_ID_W + DATA_W,
  parameter int ARB_MODE = 1,
  localparam int PTR_W   = (N_UNITS > 1) ? $clog2(N_UNITS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [N_UNITS-1:0]              i_valid,
  input  logic [N_UNITS-1:0][CDB_W-1:0]   i_data,
  output logic [N_UNITS-1:0]              i_ready,
  output logic [N_LANES-1:0][CDB_W-1:0]   o_cdb,
  output logic [N_LANES-1:0]              o_cdb_valid,
  output logic [PTR_W-1:0]                o_rr_ptr
);

  if (N_LANES < 1 || N_LANES > N_UNITS) begin : g_bad_cfg
    $error("cdb_arbiter: N_LANES must be within 1..N_UNITS");
  end

  logic [N_LANES-1:0][CDB_W-1:0] lane_dat;
  logic [N_LANES-1:0]            lane_vld;
  logic [PTR_W-1:0]              ptr_nxt;
  logic                          any_gnt;

  // Walk units in priority order from the start pointer; the k-th hit lands on lane k.
  always_comb begin
    int  start;
    int  idx;
    int  cnt;
    int  last;
    logic hit;
    i_ready  = '0;
    lane_dat = '0;
    lane_vld = '0;
    any_gnt  = 1'b0;
    cnt      = 0;
    last     = 0;
    idx      = 0;
    hit      = 1'b0;
    start    = (ARB_MODE == 1) ? int'(o_rr_ptr) : 0;
    for (int i = 0; i < N_UNITS; i++) begin
      idx = start + i;
      if (idx >= N_UNITS) idx = idx - N_UNITS;
      hit = 1'b0;
      for (int j = 0; j < N_UNITS; j++) begin
        if (j == idx && i_valid[j] && cnt < N_LANES && !rst && !flush) begin
          i_ready[j] = 1'b1;
          for (int k = 0; k < N_LANES; k++) begin
            if (k == cnt) begin
              lane_dat[k] = i_data[j];
              lane_vld[k] = 1'b1;
            end
          end
          last    = j;
          any_gnt = 1'b1;
          hit     = 1'b1;
        end
      end
      if (hit) cnt = cnt + 1;
    end
    ptr_nxt = (last + 1 >= N_UNITS) ? '0 : PTR_W'(last + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_cdb       <= '0;
      o_cdb_valid <= '0;
      o_rr_ptr    <= '0;
    end else begin
      o_cdb_valid <= lane_vld;
      for (int k = 0; k < N_LANES; k++) begin
        if (lane_vld[k]) o_cdb[k] <= lane_dat[k];
      end
      // Flush and idle cycles produce no grant, so the pointer holds.
      if (ARB_MODE == 1 && any_gnt) o_rr_ptr <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter across four configurations sharing one clock and reset.
module tb_cdb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  // dut0: 3 units/1 lane RR, dut1: 3/1 fixed, dut2: 4/2 RR, dut3: 3/3 RR
  logic [2:0]        v0, v1, v3;
  logic [3:0]        v2;
  logic [2:0][39:0]  d0, d1, d3;
  logic [3:0][39:0]  d2;
  logic [2:0]        r0, r1, r3;
  logic [3:0]        r2;
  logic [0:0][39:0]  c0, c1;
  logic [1:0][39:0]  c2;
  logic [2:0][39:0]  c3;
  logic [0:0]        cv0, cv1;
  logic [1:0]        cv2;
  logic [2:0]        cv3;
  logic [1:0]        p0, p1, p2, p3;

  cdb_arbiter #(.N_UNITS(3), .N_LANES(1), .ARB_MODE(1)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(v0), .i_data(d0), .i_ready(r0),
    .o_cdb(c0), .o_cdb_valid(cv0), .o_rr_ptr(p0));
  cdb_arbiter #(.N_UNITS(3), .N_LANES(1), .ARB_MODE(0)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(v1), .i_data(d1), .i_ready(r1),
    .o_cdb(c1), .o_cdb_valid(cv1), .o_rr_ptr(p1));
  cdb_arbiter #(.N_UNITS(4), .N_LANES(2), .ARB_MODE(1)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(v2), .i_data(d2), .i_ready(r2),
    .o_cdb(c2), .o_cdb_valid(cv2), .o_rr_ptr(p2));
  cdb_arbiter #(.N_UNITS(3), .N_LANES(3), .ARB_MODE(1)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush), .i_valid(v3), .i_data(d3), .i_ready(r3),
    .o_cdb(c3), .o_cdb_valid(cv3), .o_rr_ptr(p3));

  typedef struct {
    int          dut;
    int          due;
    logic [119:0] cdb;
    logic [2:0]  vld;
    logic [1:0]  ptr;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [39:0] pay(input int u);
    return {8'(9 + u), 32'(16 + u)};
  endfunction

  task automatic expect_out(input int dut, input logic [119:0] cdb, input logic [2:0] vld,
                            input logic [1:0] ptr, input string tag);
    exp_t e;
    e.dut = dut; e.due = cyc + 1; e.cdb = cdb; e.vld = vld; e.ptr = ptr; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic tick();
    exp_t         e;
    logic [119:0] acdb, mask;
    logic [2:0]   avld;
    logic [1:0]   aptr;
    @(negedge clk);
    cyc++;
    while (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      case (e.dut)
        0:       begin acdb = 120'(c0); avld = 3'(cv0); aptr = p0; end
        1:       begin acdb = 120'(c1); avld = 3'(cv1); aptr = p1; end
        2:       begin acdb = 120'(c2); avld = 3'(cv2); aptr = p2; end
        default: begin acdb = 120'(c3); avld = cv3;     aptr = p3; end
      endcase
      mask = '0;
      for (int k = 0; k < 3; k++) if (e.vld[k]) mask[k*40 +: 40] = '1;
      chk({e.tag, ".vld"}, 128'(avld), 128'(e.vld));
      chk({e.tag, ".cdb"}, 128'(acdb & mask), 128'(e.cdb & mask));
      chk({e.tag, ".ptr"}, 128'(aptr), 128'(e.ptr));
    end
  endtask

  int exp_g[6] = '{0, 1, 2, 0, 1, 2};
  int exp_p[6] = '{1, 2, 0, 1, 2, 0};

  initial begin
    for (int u = 0; u < 3; u++) begin d0[u] = pay(u); d1[u] = pay(u); d3[u] = pay(u); end
    for (int u = 0; u < 4; u++) d2[u] = pay(u);
    v0 = '1; v1 = '1; v2 = '1; v3 = '1;

    // Reset held two cycles with every unit requesting
    for (int n = 0; n < 2; n++) begin
      tick();
      #1;
      chk("rst_rdy0", 128'(r0), 128'(0));
      chk("rst_rdy2", 128'(r2), 128'(0));
      expect_out(0, '0, 3'b000, 2'd0, "rst_out0");
      expect_out(2, '0, 3'b000, 2'd0, "rst_out2");
    end
    tick();
    rst = 1'b0; v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    #1;
    expect_out(0, '0, 3'b000, 2'd0, "rel_out0");

    // Single lane round-robin, all units valid
    for (int n = 0; n < 6; n++) begin
      tick();
      v0 = 3'b111;
      #1;
      chk($sformatf("rr_rdy%0d", n), 128'(r0), 128'(3'b001 << exp_g[n]));
      expect_out(0, 120'(pay(exp_g[n])), 3'b001, 2'(exp_p[n]), $sformatf("rr_out%0d", n));
    end

    // Flush blocks the grant and holds the pointer; unit 1 wins next cycle
    tick();
    v0 = 3'b010; flush = 1'b1;
    #1;
    chk("fl_rdy", 128'(r0), 128'(0));
    expect_out(0, '0, 3'b000, 2'd0, "fl_out");
    tick();
    flush = 1'b0;
    #1;
    chk("pfl_rdy", 128'(r0), 128'(3'b010));
    expect_out(0, 120'(pay(1)), 3'b001, 2'd2, "pfl_out");
    tick();
    v0 = 3'b000;
    #1;
    chk("idle_rdy", 128'(r0), 128'(0));
    expect_out(0, '0, 3'b000, 2'd2, "idle_out");

    // Fixed priority: unit 2 starves behind unit 0
    for (int n = 0; n < 3; n++) begin
      tick();
      v1 = 3'b101;
      #1;
      chk($sformatf("fp_rdy%0d", n), 128'(r1), 128'(3'b001));
      expect_out(1, 120'(pay(0)), 3'b001, 2'd0, $sformatf("fp_out%0d", n));
    end
    tick();
    v1 = '0;

    // Two lanes: walk pointer to 3, then valid=1011 wraps to units 3 and 0
    v2 = 4'b0111;
    #1;
    chk("l2_rdy_a", 128'(r2), 128'(4'b0011));
    expect_out(2, {40'd0, pay(1), pay(0)}, 3'b011, 2'd2, "l2_out_a");
    tick();
    v2 = 4'b0100;
    #1;
    chk("l2_rdy_b", 128'(r2), 128'(4'b0100));
    expect_out(2, 120'(pay(2)), 3'b001, 2'd3, "l2_out_b");
    tick();
    v2 = 4'b1011;
    #1;
    chk("l2_rdy_c", 128'(r2), 128'(4'b1001));
    expect_out(2, {40'd0, pay(0), pay(3)}, 3'b011, 2'd1, "l2_out_c");
    tick();
    v2 = '0;

    // Three lanes: under- and full subscription
    v3 = 3'b100;
    #1;
    chk("l3_rdy_a", 128'(r3), 128'(3'b100));
    expect_out(3, 120'(pay(2)), 3'b001, 2'd0, "l3_out_a");
    tick();
    v3 = 3'b111;
    #1;
    chk("l3_rdy_b", 128'(r3), 128'(3'b111));
    expect_out(3, {pay(2), pay(1), pay(0)}, 3'b111, 2'd0, "l3_out_b");
    tick();
    v3 = 3'b011;
    #1;
    chk("l3_rdy_c", 128'(r3), 128'(3'b011));
    expect_out(3, {40'd0, pay(1), pay(0)}, 3'b011, 2'd2, "l3_out_c");
    tick();
    v3 = '0;

    // Reset together with flush mid-stream discards the grant
    v0 = 3'b111; rst = 1'b1; flush = 1'b1;
    #1;
    chk("mrst_rdy", 128'(r0), 128'(0));
    expect_out(0, '0, 3'b000, 2'd0, "mrst_out");
    tick();
    rst = 1'b0; flush = 1'b0; v0 = '0;
    tick();
    chk("sb_drain", 128'(q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
